// File: rtl/mac_sequencer.sv
// Initiator-side sequencer for the signed MAC: accepts operand pairs, issues one
// term at a time, and feeds each MAC result back as the next accumulator input.
// On the last term it requantizes the sum (round, shift, saturate, optional ReLU)
// and presents it on a ready/valid result port.
module mac_sequencer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ACC_WIDTH   = 40,
    parameter int unsigned MAC_LATENCY = 3,
    parameter int unsigned SHIFT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_a,
    input  logic [DATA_WIDTH-1:0]  in_b,
    input  logic                   in_last,
    input  logic [ACC_WIDTH-1:0]   bias_in,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic                   cfg_relu,
    output logic                   mac_en,
    output logic                   mac_valid_in,
    output logic [DATA_WIDTH-1:0]  mac_a,
    output logic [DATA_WIDTH-1:0]  mac_b,
    output logic [ACC_WIDTH-1:0]   mac_acc_in,
    input  logic [ACC_WIDTH-1:0]   mac_acc_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [ACC_WIDTH-1:0]   out_acc
);

    typedef enum logic [1:0] {StAccept, StIssue, StWait, StOut} state_e;

    localparam logic [3:0] CntLoad = 4'(MAC_LATENCY - 1);

    // Saturation bounds at ACC_WIDTH+1 precision.
    localparam logic signed [ACC_WIDTH:0] SatMax =
        {{(ACC_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SatMin =
        {{(ACC_WIDTH - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    state_e                 state_q, state_d;
    logic                   first_q, first_d;
    logic                   last_q, last_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic                   relu_q, relu_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   in_ready_q, in_ready_d;
    logic                   issue_q, issue_d;
    logic [DATA_WIDTH-1:0]  mac_a_q, mac_a_d;
    logic [DATA_WIDTH-1:0]  mac_b_q, mac_b_d;
    logic [ACC_WIDTH-1:0]   mac_acc_in_q, mac_acc_in_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [ACC_WIDTH-1:0]   out_acc_q, out_acc_d;

    // Round-half-up, arithmetic shift, saturate, then optional ReLU.
    function automatic logic [DATA_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0]   x,
                                                      input logic [SHIFT_WIDTH-1:0] sh,
                                                      input logic                   relu);
        logic signed [ACC_WIDTH:0] xe;
        logic signed [ACC_WIDTH:0] rnd;
        logic signed [ACC_WIDTH:0] r;
        xe  = {x[ACC_WIDTH-1], x};
        rnd = '0;
        if (sh != '0) begin
            rnd = {{ACC_WIDTH{1'b0}}, 1'b1} << (sh - 1'b1);
        end
        r = (xe + rnd) >>> sh;
        if (r > SatMax) begin
            r = SatMax;
        end else if (r < SatMin) begin
            r = SatMin;
        end
        if (relu && r[ACC_WIDTH]) begin
            r = '0;
        end
        return r[DATA_WIDTH-1:0];
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        last_d       = last_q;
        shift_d      = shift_q;
        relu_d       = relu_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mac_a_d      = mac_a_q;
        mac_b_d      = mac_b_q;
        mac_acc_in_d = mac_acc_in_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_acc_d    = out_acc_q;

        unique case (state_q)
            StAccept: begin
                if (in_valid && in_ready_q) begin
                    mac_a_d      = in_a;
                    mac_b_d      = in_b;
                    last_d       = in_last;
                    mac_acc_in_d = first_q ? bias_in : acc_q;
                    if (in_last) begin
                        shift_d = cfg_shift;
                        relu_d  = cfg_relu;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CntLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    acc_d   = mac_acc_out;
                    first_d = 1'b0;
                    if (last_q) begin
                        out_acc_d   = mac_acc_out;
                        out_data_d  = requant(mac_acc_out, shift_q, relu_q);
                        out_valid_d = 1'b1;
                        state_d     = StOut;
                    end else begin
                        state_d = StAccept;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StOut: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    first_d     = 1'b1;
                    state_d     = StAccept;
                end
            end
            default: state_d = StAccept;
        endcase

        // Handshake strobes are registered from the next state so they are glitch-free.
        in_ready_d = (state_d == StAccept);
        issue_d    = (state_d == StIssue);
    end

    // State and output registers; reset discards any in-flight term or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StAccept;
            first_q      <= 1'b1;
            last_q       <= 1'b0;
            shift_q      <= '0;
            relu_q       <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            in_ready_q   <= 1'b0;
            issue_q      <= 1'b0;
            mac_a_q      <= '0;
            mac_b_q      <= '0;
            mac_acc_in_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_acc_q    <= '0;
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            last_q       <= last_d;
            shift_q      <= shift_d;
            relu_q       <= relu_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            in_ready_q   <= in_ready_d;
            issue_q      <= issue_d;
            mac_a_q      <= mac_a_d;
            mac_b_q      <= mac_b_d;
            mac_acc_in_q <= mac_acc_in_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_acc_q    <= out_acc_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mac_en       = issue_q;
    assign mac_valid_in = issue_q;
    assign mac_a        = mac_a_q;
    assign mac_b        = mac_b_q;
    assign mac_acc_in   = mac_acc_in_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_acc      = out_acc_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: two instances (MAC latency 3 and 1), each with a
// behavioural MAC pipeline; sel picks which one the stimulus tasks drive and observe.
module tb_mac_sequencer;

    localparam int DW = 16;
    localparam int AW = 40;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          cfg_relu = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [AW-1:0] bias_in = '0;
    logic [SW-1:0] cfg_shift = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Instance with MAC_LATENCY=3
    logic          in_ready_3, mac_en_3, mac_vin_3, out_valid_3;
    logic [DW-1:0] mac_a_3, mac_b_3, out_data_3;
    logic [AW-1:0] mac_acc_in_3, mac_acc_out_3, out_acc_3;
    // Instance with MAC_LATENCY=1
    logic          in_ready_1, mac_en_1, mac_vin_1, out_valid_1;
    logic [DW-1:0] mac_a_1, mac_b_1, out_data_1;
    logic [AW-1:0] mac_acc_in_1, mac_acc_out_1, out_acc_1;

    mac_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAC_LATENCY(3), .SHIFT_WIDTH(SW)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(in_ready_3),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .bias_in(bias_in),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .mac_en(mac_en_3),
        .mac_valid_in(mac_vin_3), .mac_a(mac_a_3), .mac_b(mac_b_3),
        .mac_acc_in(mac_acc_in_3), .mac_acc_out(mac_acc_out_3), .out_valid(out_valid_3),
        .out_ready(out_ready && !sel), .out_data(out_data_3), .out_acc(out_acc_3)
    );

    mac_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAC_LATENCY(1), .SHIFT_WIDTH(SW)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(in_ready_1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .bias_in(bias_in),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .mac_en(mac_en_1),
        .mac_valid_in(mac_vin_1), .mac_a(mac_a_1), .mac_b(mac_b_1),
        .mac_acc_in(mac_acc_in_1), .mac_acc_out(mac_acc_out_1), .out_valid(out_valid_1),
        .out_ready(out_ready && sel), .out_data(out_data_1), .out_acc(out_acc_1)
    );

    function automatic logic [AW-1:0] mac_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [AW-1:0] acc);
        logic [AW-1:0] sa, sb;
        sa = {{(AW - DW){a[DW-1]}}, a};
        sb = {{(AW - DW){b[DW-1]}}, b};
        return acc + sa * sb;
    endfunction

    // Behavioural MACs: result visible MAC_LATENCY edges after the sampling edge.
    logic [AW-1:0] p3 [3];
    logic [AW-1:0] p1;
    always @(posedge clk) begin
        p3[0] <= (mac_en_3 && mac_vin_3) ? mac_fn(mac_a_3, mac_b_3, mac_acc_in_3) : '0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        p1    <= (mac_en_1 && mac_vin_1) ? mac_fn(mac_a_1, mac_b_1, mac_acc_in_1) : '0;
    end
    assign mac_acc_out_3 = p3[2];
    assign mac_acc_out_1 = p1;

    // Views of the selected instance.
    logic          v_in_ready, v_mac_en, v_mac_vin, v_out_valid;
    logic [DW-1:0] v_mac_a, v_mac_b, v_out_data;
    logic [AW-1:0] v_mac_acc_in, v_out_acc;
    assign v_in_ready   = sel ? in_ready_1   : in_ready_3;
    assign v_mac_en     = sel ? mac_en_1     : mac_en_3;
    assign v_mac_vin    = sel ? mac_vin_1    : mac_vin_3;
    assign v_out_valid  = sel ? out_valid_1  : out_valid_3;
    assign v_mac_a      = sel ? mac_a_1      : mac_a_3;
    assign v_mac_b      = sel ? mac_b_1      : mac_b_3;
    assign v_out_data   = sel ? out_data_1   : out_data_3;
    assign v_mac_acc_in = sel ? mac_acc_in_1 : mac_acc_in_3;
    assign v_out_acc    = sel ? out_acc_1    : out_acc_3;

    // Log every issued term and count pulses wider than one cycle.
    int            pulse_cnt = 0;
    int            wide_cnt = 0;
    logic          prev_vin = 1'b0;
    logic [AW-1:0] acc_log [32];
    always @(posedge clk) begin
        if (v_mac_en && v_mac_vin) begin
            if (pulse_cnt < 32) acc_log[pulse_cnt] <= v_mac_acc_in;
            pulse_cnt <= pulse_cnt + 1;
        end
        prev_vin <= v_mac_vin;
        if (prev_vin && v_mac_vin) wide_cnt <= wide_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_term(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
        int n = 0;
        while (!v_in_ready && n < 100) begin
            tick;
            n++;
        end
        if (!v_in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_term timeout: in_ready=%b required 1", v_in_ready);
        end
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out;
        int n = 0;
        while (!v_out_valid && n < 100) begin
            tick;
            n++;
        end
        if (!v_out_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_out timeout: out_valid=%b required 1", v_out_valid);
        end
    endtask

    task automatic pop_out;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    // Single-term dot product; config is scrambled after issue to prove it was latched.
    task automatic run_single(input logic [AW-1:0] bias, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [SW-1:0] sh,
                              input logic relu);
        bias_in   = bias;
        cfg_shift = sh;
        cfg_relu  = relu;
        send_term(a, b, 1'b1);
        bias_in   = 40'd77777;
        cfg_shift = 6'd17;
        cfg_relu  = ~relu;
        wait_out;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
    endtask

    task automatic test_reset;
        vectors++;
        if ({v_in_ready, v_out_valid, v_mac_en, v_mac_vin} !== 4'b0000 || v_mac_a !== '0 ||
            v_mac_b !== '0 || v_mac_acc_in !== '0 || v_out_data !== '0 || v_out_acc !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy/ov/en/vin=%b%b%b%b a=%h b=%h acc_in=%h data=%h acc=%h required all 0",
                     v_in_ready, v_out_valid, v_mac_en, v_mac_vin, v_mac_a, v_mac_b,
                     v_mac_acc_in, v_out_data, v_out_acc);
        end
        rst_n = 1'b1;
        tick;
        vectors++;
        if (in_ready_3 !== 1'b1 || in_ready_1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: in_ready3=%b in_ready1=%b required 1 1",
                     in_ready_3, in_ready_1);
        end
    endtask

    task automatic test_basic(input int lat);
        int            base;
        int            wbase;
        logic [AW-1:0] exp_acc [3];
        exp_acc = '{40'd100, 40'd112, 40'd102};
        base  = pulse_cnt;
        wbase = wide_cnt;
        bias_in = 40'd100;
        send_term(16'd3, 16'd4, 1'b0);
        bias_in = 40'd9999;
        send_term(16'hFFFE, 16'd5, 1'b0);
        send_term(16'd7, 16'd7, 1'b1);
        wait_out;
        vectors++;
        if (v_out_acc !== 40'd151) begin
            miscompares++;
            $display("FAIL basic_out_acc(lat %0d): got %0d required 151", lat, $signed(v_out_acc));
        end
        vectors++;
        if (v_out_data !== 16'd151) begin
            miscompares++;
            $display("FAIL basic_out_data(lat %0d): got %0d required 151", lat, $signed(v_out_data));
        end
        vectors++;
        if (pulse_cnt - base !== 3 || wide_cnt !== wbase) begin
            miscompares++;
            $display("FAIL basic_pulses(lat %0d): got %0d pulses, %0d wide; required 3, 0",
                     lat, pulse_cnt - base, wide_cnt - wbase);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (acc_log[base+i] !== exp_acc[i]) begin
                miscompares++;
                $display("FAIL basic_acc_in[%0d](lat %0d): got %0d required %0d",
                         i, lat, $signed(acc_log[base+i]), exp_acc[i]);
            end
        end
        pop_out;
    endtask

    task automatic test_rounding(input int lat);
        logic [AW-1:0] bias_t [4];
        logic [SW-1:0] sh_t [4];
        logic [DW-1:0] exp_t [4];
        bias_t = '{40'd151, AW'(-151), 40'd3, AW'(-3)};
        sh_t   = '{6'd2, 6'd2, 6'd1, 6'd1};
        exp_t  = '{16'd38, 16'(-38), 16'd2, 16'(-1)};
        for (int i = 0; i < 4; i++) begin
            run_single(bias_t[i], 16'd0, 16'd0, sh_t[i], 1'b0);
            vectors++;
            if (v_out_data !== exp_t[i] || v_out_acc !== bias_t[i]) begin
                miscompares++;
                $display("FAIL rounding[%0d](lat %0d): got data=%0d acc=%0d required data=%0d acc=%0d",
                         i, lat, $signed(v_out_data), $signed(v_out_acc), $signed(exp_t[i]),
                         $signed(bias_t[i]));
            end
            pop_out;
        end
    endtask

    task automatic test_saturation;
        logic [AW-1:0] bias_t [4];
        logic [DW-1:0] a_t [4];
        logic [DW-1:0] b_t [4];
        logic [AW-1:0] acc_t [4];
        logic [DW-1:0] exp_t [4];
        bias_t = '{40'd0, 40'd0, 40'd32768, AW'(-32769)};
        a_t    = '{16'd16384, 16'h8000, 16'd0, 16'd0};
        b_t    = '{16'd16384, 16'd32767, 16'd0, 16'd0};
        acc_t  = '{40'd268435456, AW'(-1073709056), 40'd32768, AW'(-32769)};
        exp_t  = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        for (int i = 0; i < 4; i++) begin
            run_single(bias_t[i], a_t[i], b_t[i], 6'd0, 1'b0);
            vectors++;
            if (v_out_data !== exp_t[i] || v_out_acc !== acc_t[i]) begin
                miscompares++;
                $display("FAIL saturation[%0d]: got data=%0d acc=%0d required data=%0d acc=%0d",
                         i, $signed(v_out_data), $signed(v_out_acc), $signed(exp_t[i]),
                         $signed(acc_t[i]));
            end
            pop_out;
        end
    endtask

    task automatic test_relu;
        run_single(AW'(-500), 16'd1, 16'd1, 6'd0, 1'b1);
        vectors++;
        if (v_out_data !== 16'd0 || v_out_acc !== AW'(-499)) begin
            miscompares++;
            $display("FAIL relu_negative: got data=%0d acc=%0d required data=0 acc=-499",
                     $signed(v_out_data), $signed(v_out_acc));
        end
        pop_out;
        run_single(40'd10, 16'd1, 16'd1, 6'd0, 1'b1);
        vectors++;
        if (v_out_data !== 16'd11) begin
            miscompares++;
            $display("FAIL relu_positive: got data=%0d required 11", $signed(v_out_data));
        end
        pop_out;
        run_single(AW'(-500), 16'd1, 16'd1, 6'd0, 1'b0);
        vectors++;
        if (v_out_data !== 16'(-499)) begin
            miscompares++;
            $display("FAIL relu_off: got data=%0d required -499", $signed(v_out_data));
        end
        pop_out;
    endtask

    task automatic test_backpressure;
        bias_in = 40'd1000;
        send_term(16'd10, 16'd10, 1'b0);
        bias_in = 40'd9999;
        send_term(16'hFFFB, 16'd4, 1'b1);
        wait_out;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (v_out_valid !== 1'b1 || v_in_ready !== 1'b0 || v_out_data !== 16'd1080 ||
                v_out_acc !== 40'd1080) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: got ov=%b rdy=%b data=%0d acc=%0d required 1 0 1080 1080",
                         i, v_out_valid, v_in_ready, $signed(v_out_data), $signed(v_out_acc));
            end
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vectors++;
        if (v_out_valid !== 1'b0 || v_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release: got ov=%b rdy=%b required 0 1",
                     v_out_valid, v_in_ready);
        end
        run_single(40'd7, 16'd2, 16'd3, 6'd0, 1'b0);
        vectors++;
        if (v_out_acc !== 40'd13 || v_out_data !== 16'd13) begin
            miscompares++;
            $display("FAIL backpressure_new_bias: got acc=%0d data=%0d required 13 13",
                     $signed(v_out_acc), $signed(v_out_data));
        end
        pop_out;
    endtask

    task automatic test_reset_mid;
        bias_in = 40'd50;
        send_term(16'd1, 16'd1, 1'b0);
        bias_in = 40'd9999;
        send_term(16'd2, 16'd2, 1'b1);
        tick;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({v_in_ready, v_out_valid, v_mac_en, v_mac_vin} !== 4'b0000 || v_mac_a !== '0 ||
            v_mac_b !== '0 || v_mac_acc_in !== '0 || v_out_data !== '0 || v_out_acc !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: rdy/ov/en/vin=%b%b%b%b a=%h b=%h acc_in=%h required all 0",
                     v_in_ready, v_out_valid, v_mac_en, v_mac_vin, v_mac_a, v_mac_b, v_mac_acc_in);
        end
        repeat (4) tick;
        rst_n = 1'b1;
        tick;
        vectors++;
        if (v_in_ready !== 1'b1 || v_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_release: got rdy=%b ov=%b required 1 0", v_in_ready, v_out_valid);
        end
        run_single(40'd5, 16'd2, 16'd3, 6'd0, 1'b0);
        vectors++;
        if (v_out_acc !== 40'd11 || v_out_data !== 16'd11) begin
            miscompares++;
            $display("FAIL reset_mid_result: got acc=%0d data=%0d required 11 11",
                     $signed(v_out_acc), $signed(v_out_data));
        end
        pop_out;
    endtask

    initial begin
        repeat (3) tick;
        test_reset;
        test_basic(3);
        test_rounding(3);
        test_saturation;
        test_relu;
        test_backpressure;
        test_reset_mid;
        sel = 1'b1;
        tick;
        test_basic(1);
        test_rounding(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

endmodule
